// File: rtl/median_filter_pkg.sv
// Shared types and constants for the median filter read path.
//   fetch_state_t  : window fetch sequencer states
//   TAP_DR/TAP_DC  : row/column offsets of window tap k (k = 3*(dr+1)+(dc+1))
//   WIN_BITS       : packed 3x3 window width (9 taps x 8 bits)
//   RD_LATENCY     : image RAM read latency in cycles
package median_filter_pkg;

    localparam int unsigned TAP_N      = 9;
    localparam int unsigned TAP_IDX_W  = 4;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned WIN_BITS   = 72;
    localparam int unsigned RD_LATENCY = 2;

    localparam int TAP_DR [TAP_N] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int TAP_DC [TAP_N] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/median_window_fetch_if.sv
// RAM read port and window output handshake of the window fetch sequencer.
//   master : sequencer side (drives reads and presents windows)
//   slave  : RAM + downstream median stage side
interface median_window_fetch_if
    import median_filter_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H) + 1
);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);

    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [PIX_W-1:0]    rd_data;
    logic                win_valid;
    logic                win_ready;
    logic [WIN_BITS-1:0] win_data;
    logic [ROW_W-1:0]    win_row;
    logic [COL_W-1:0]    win_col;

    modport master (
        output rd_en, rd_addr, win_valid, win_data, win_row, win_col,
        input  rd_data, win_ready
    );

    modport slave (
        input  rd_en, rd_addr, win_valid, win_data, win_row, win_col,
        output rd_data, win_ready
    );

endinterface

// File: rtl/median_window_fetch_addr_gen.sv
// Combinational address generator: (row, col, tap k) -> clamped RAM address.
// Clamping to the image edges replicates border pixels.
//   row_i, col_i : window centre
//   k_i          : tap index 0..8
//   addr_o       : clamp(row+dr)*IMG_W + clamp(col+dc)
module window_addr_gen
    import median_filter_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H) + 1,
    parameter int unsigned ROW_W  = $clog2(IMG_H),
    parameter int unsigned COL_W  = $clog2(IMG_W)
) (
    input  logic [ROW_W-1:0]     row_i,
    input  logic [COL_W-1:0]     col_i,
    input  logic [TAP_IDX_W-1:0] k_i,
    output logic [ADDR_W-1:0]    addr_o
);

    logic [TAP_IDX_W-1:0] tap;
    int                   r_s;
    int                   c_s;
    int                   r_c;
    int                   c_c;

    // Clamp before the multiply so the product never exceeds IMG_W*IMG_H-1.
    always_comb begin
        tap = (k_i < TAP_IDX_W'(TAP_N)) ? k_i : TAP_IDX_W'(TAP_N - 1);
        r_s = int'({1'b0, row_i}) + TAP_DR[tap];
        c_s = int'({1'b0, col_i}) + TAP_DC[tap];
        r_c = r_s;
        c_c = c_s;
        if (r_s < 0)                    r_c = 0;
        else if (r_s > int'(IMG_H) - 1) r_c = int'(IMG_H) - 1;
        if (c_s < 0)                    c_c = 0;
        else if (c_s > int'(IMG_W) - 1) c_c = int'(IMG_W) - 1;
        addr_o = ADDR_W'(r_c * int'(IMG_W) + c_c);
    end

endmodule

// File: rtl/median_window_fetch.sv
// Read-side sequencer for the image RAM: for each pixel in raster order it
// issues the nine 3x3 neighbourhood reads, absorbs the RAM read latency and
// presents the assembled window over a valid/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a frame scan (sampled in IDLE only)
//   busy       : frame scan in progress
//   done       : one-cycle pulse after the last window handshake
//   bus        : RAM read port + window output (master modport)
module median_window_fetch
    import median_filter_pkg::*;
#(
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    median_window_fetch_if.master bus
);

    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);

    fetch_state_t         state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [TAP_IDX_W-1:0] k_q, k_d;
    logic [1:0]           drain_q, drain_d;

    logic                 busy_q, done_q, rd_en_q, win_valid_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [ADDR_W-1:0]    addr_c;
    logic [TAP_IDX_W-1:0] rd_tap_q;
    logic [RD_LATENCY-1:0] infl_vld_q;
    logic [TAP_IDX_W-1:0] infl_tap_q [RD_LATENCY];
    logic [WIN_BITS-1:0]  win_q;

    // Address for the read issued next cycle, computed from next-state coordinates.
    window_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_addr_gen (
        .row_i (row_d),
        .col_i (col_d),
        .k_i   (k_d),
        .addr_o(addr_c)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                if (k_q == TAP_IDX_W'(TAP_N - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + TAP_IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'(RD_LATENCY - 1)) state_d = S_OUT;
                else                                drain_d = drain_q + 2'(1);
            end
            S_OUT: begin
                if (bus.win_ready) begin
                    k_d = '0;
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(IMG_H - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, registered outputs and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_tap_q    <= '0;
            win_valid_q <= 1'b0;
            infl_vld_q  <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) infl_tap_q[i] <= '0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            rd_en_q     <= (state_d == S_FETCH);
            win_valid_q <= (state_d == S_OUT);
            if (state_d == S_FETCH) begin
                rd_addr_q <= addr_c;
                rd_tap_q  <= k_d;
            end
            infl_vld_q    <= {infl_vld_q[RD_LATENCY-2:0], rd_en_q};
            infl_tap_q[0] <= rd_tap_q;
            for (int i = 1; i < int'(RD_LATENCY); i++) infl_tap_q[i] <= infl_tap_q[i-1];
            // Returning read lands in the slot of the tap that issued it.
            if (infl_vld_q[RD_LATENCY-1]) begin
                for (int i = 0; i < int'(TAP_N); i++) begin
                    if (infl_tap_q[RD_LATENCY-1] == TAP_IDX_W'(i)) win_q[8*i +: 8] <= bus.rd_data;
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_q;
    assign bus.win_row   = row_q;
    assign bus.win_col   = col_q;

endmodule

// File: tb/tb_median_window_fetch.sv
// Directed bench for median_window_fetch on a 4x4 image with mem[a] = a.
module tb_median_window_fetch;

    localparam int unsigned IMG_W    = 4;
    localparam int unsigned IMG_H    = 4;
    localparam int          WAIT_MAX = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

    logic [7:0] ram_p1;

    median_window_fetch_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    median_window_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // RAM model: data = address, two-cycle latency.
    always @(posedge clk) begin
        ram_p1      <= 8'(bus.rd_addr);
        bus.rd_data <= ram_p1;
    end

    always @(posedge clk) begin
        if (rst_n && bus.win_valid && bus.win_ready) hs_cnt++;
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [71:0] w9(input int t0, input int t1, input int t2,
                                       input int t3, input int t4, input int t5,
                                       input int t6, input int t7, input int t8);
        return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n, output int rds);
        n   = 0;
        rds = 0;
        while (!bus.win_valid && n < WAIT_MAX) begin
            if (bus.rd_en) rds++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic next_pixel(output int n, output int rds);
        @(negedge clk);
        wait_valid(n, rds);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},      72'(busy),          72'(0));
        chk({tag, "_done"},      72'(done),          72'(0));
        chk({tag, "_rd_en"},     72'(bus.rd_en),     72'(0));
        chk({tag, "_win_valid"}, 72'(bus.win_valid), 72'(0));
        chk({tag, "_rd_addr"},   72'(bus.rd_addr),   72'(0));
        chk({tag, "_win_data"},  bus.win_data,       72'(0));
        chk({tag, "_win_row"},   72'(bus.win_row),   72'(0));
        chk({tag, "_win_col"},   72'(bus.win_col),   72'(0));
    endtask

    initial begin
        int n;
        int rds;
        int hs0;
        int dn0;

        rst_n         = 1'b0;
        start         = 1'b0;
        bus.win_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy",  72'(busy),      72'(0));
        chk("idle_rd_en", 72'(bus.rd_en), 72'(0));

        hs0 = hs_cnt;
        dn0 = done_cnt;

        // Frame start; the next negedge is FETCH cycle 0.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("c0_busy",    72'(busy),        72'(1));
        chk("c0_rd_en",   72'(bus.rd_en),   72'(1));
        chk("c0_rd_addr", 72'(bus.rd_addr), 72'(0));

        wait_valid(n, rds);
        chk("lat_00",   72'(n),           72'(11));
        chk("reads_00", 72'(rds),         72'(9));
        chk("data_00",  bus.win_data,     w9(0, 0, 1, 0, 0, 1, 4, 4, 5));
        chk("row_00",   72'(bus.win_row), 72'(0));
        chk("col_00",   72'(bus.win_col), 72'(0));

        for (int p = 1; p <= 4; p++) begin
            next_pixel(n, rds);
            chk("period",  72'(n),           72'(11));
            chk("p_row",   72'(bus.win_row), 72'(p / 4));
            chk("p_col",   72'(bus.win_col), 72'(p % 4));
        end

        next_pixel(n, rds);
        chk("row_11",  72'(bus.win_row), 72'(1));
        chk("col_11",  72'(bus.win_col), 72'(1));
        chk("data_11", bus.win_data,     w9(0, 1, 2, 4, 5, 6, 8, 9, 10));

        // Backpressure on (1,2).
        next_pixel(n, rds);
        chk("data_12", bus.win_data, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        bus.win_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 72'(bus.win_valid), 72'(1));
            chk("bp_rd_en", 72'(bus.rd_en),     72'(0));
            chk("bp_data",  bus.win_data,       w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
            chk("bp_row",   72'(bus.win_row),   72'(1));
            chk("bp_col",   72'(bus.win_col),   72'(2));
        end
        bus.win_ready = 1'b1;

        next_pixel(n, rds);
        chk("row_13",  72'(bus.win_row), 72'(1));
        chk("col_13",  72'(bus.win_col), 72'(3));
        chk("data_13", bus.win_data,     w9(2, 3, 3, 6, 7, 7, 10, 11, 11));

        for (int p = 8; p < 16; p++) begin
            @(negedge clk);
            if (p == 9) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("mid_start_busy", 72'(busy), 72'(1));
            end
            wait_valid(n, rds);
            chk("f_row", 72'(bus.win_row), 72'(p / 4));
            chk("f_col", 72'(bus.win_col), 72'(p % 4));
        end
        chk("data_33", bus.win_data, w9(10, 11, 11, 14, 15, 15, 14, 15, 15));

        @(negedge clk);
        chk("done_pulse",    72'(done),           72'(1));
        chk("done_busy",     72'(busy),           72'(1));
        chk("hs_count",      72'(hs_cnt - hs0),   72'(16));
        @(negedge clk);
        chk("done_low",      72'(done),           72'(0));
        chk("end_busy",      72'(busy),           72'(0));
        chk("done_count",    72'(done_cnt - dn0), 72'(1));
        repeat (3) @(negedge clk);
        chk("post_idle_rd",  72'(bus.rd_en),      72'(0));
        chk("post_idle_bsy", 72'(busy),           72'(0));
        chk("hs_count_end",  72'(hs_cnt - hs0),   72'(16));

        // Reset during FETCH cycle 5.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_stale", bus.win_data, 72'(0));
        chk("midrst_idle",  72'(busy),    72'(0));

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(n, rds);
        chk("re_lat",  72'(n),           72'(11));
        chk("re_data", bus.win_data,     w9(0, 0, 1, 0, 0, 1, 4, 4, 5));
        chk("re_row",  72'(bus.win_row), 72'(0));
        chk("re_col",  72'(bus.win_col), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
